core_sequencer: RTL and testbench

Multi-cycle control sequencer for the RISC-V core. It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives the instruction- and data-memory request handshakes. It also generates the IR, PC and register-file write strobes. The control flags it consumes come from the combinational instruction decoder (ControlUnit), which sits between the IR and this block.

---
 rtl/core_sequencer.sv | 141 ++++++++++++++
 tb/tb_core_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer driving memory handshakes and IR/PC/RF strobes.
// Define SEQ_TIMEOUT_EN to build the request wait counter and the sticky FAULT state.
module core_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             RegWrite,
  input  logic             MemWrite,
  input  logic             MemtoReg,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic [2:0]       state_o,
  output logic             fault,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    FAULT   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit;

`ifdef SEQ_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic       req_waiting;

  assign req_waiting = ((state_q == FETCH) && !imem_ack) || ((state_q == MEM) && !dmem_ack);
  // Fires on the TIMEOUT-th unacknowledged cycle, so an ack in that cycle still wins.
  assign timeout_hit = req_waiting && (wait_q == 8'(TIMEOUT - 1));

  always_comb begin
    wait_d = wait_q;
    if ((state_d == FETCH || state_d == MEM) && (state_d != state_q)) begin
      wait_d = '0;
    end else if (req_waiting) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign fault = (state_q == FAULT);
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign timeout_hit    = 1'b0;
  assign fault          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    rf_we   = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (timeout_hit) begin
          state_d = FAULT;
        end
      end
      DECODE: if (!stall_i) state_d = EXECUTE;
      EXECUTE: begin
        if (!stall_i) begin
          if (MemWrite || MemtoReg) begin
            state_d = MEM;
          end else if (RegWrite) begin
            state_d = WB;
          end else begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end
        end
      end
      MEM: begin
        if (dmem_ack) begin
          if (MemtoReg) begin
            state_d = WB;
          end else begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end
        end else if (timeout_hit) begin
          state_d = FAULT;
        end
      end
      WB: begin
        if (!stall_i) begin
          rf_we   = RegWrite;
          pc_we   = 1'b1;
          state_d = FETCH;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pc_we) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign imem_req  = (state_q == FETCH);
  assign dmem_req  = (state_q == MEM);
  assign dmem_we   = (state_q == MEM) && MemWrite;
  assign state_o   = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: per-instruction phase plans with random waits/stalls
// expand into expected per-cycle outputs that are compared against the DUT.
module tb_core_sequencer;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall_i = 1'b0, RegWrite = 1'b0, MemWrite = 1'b0, MemtoReg = 1'b0;
  logic          imem_ack = 1'b0, dmem_ack = 1'b0;
  logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, fault;
  logic [2:0]    state_o;
  logic [CW-1:0] instr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DEC = 2, S_EXE = 3, S_MEM = 4, S_WB = 5, S_FLT = 7;
  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_BR = 3;

  core_sequencer #(.TIMEOUT(16), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
    .state_o(state_o), .fault(fault), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h required 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {22'd0, fault, state_o, imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we};
  endfunction

  // One clock cycle: drive inputs just after posedge, compare on negedge.
  task automatic cyc(input int st, input bit ireq, input bit dreq, input bit dwe,
                     input bit irwe, input bit pcwe, input bit rfwe,
                     input bit stl, input bit iack, input bit dack);
    logic [31:0] exp;
    stall_i  = stl;
    imem_ack = iack;
    dmem_ack = dack;
    exp = {22'd0, 1'(st == S_FLT), 3'(st), ireq, dreq, dwe, irwe, pcwe, rfwe};
    @(negedge clk);
    check_eq("trace", obs(), exp);
    check_eq("instr_cnt", 32'(instr_cnt), 32'(exp_cnt));
    if (pcwe) exp_cnt = (exp_cnt + 1) % (1 << CW);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("reset_outputs", obs(), 32'd0);
    check_eq("reset_cnt", 32'(instr_cnt), 32'd0);
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(S_IDLE, 0, 0, 0, 0, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic set_flags(input int kind);
    RegWrite = (kind == K_R) || (kind == K_LD);
    MemWrite = (kind == K_ST);
    MemtoReg = (kind == K_LD);
  endtask

  // fd/md: unacked request cycles; sd/se/sw: stall cycles in DECODE/EXECUTE/WB.
  task automatic run_instr(input int kind, input int fd, input int sd, input int se,
                           input int md, input int sw);
    bit is_mem, is_wb, st;
    is_mem = (kind == K_LD) || (kind == K_ST);
    is_wb  = (kind == K_R) || (kind == K_LD);
    st     = (kind == K_ST);
    set_flags(kind);
    for (int i = 0; i < fd; i++) cyc(S_FETCH, 1, 0, 0, 0, 0, 0, 1'($urandom), 0, 1'($urandom));
    cyc(S_FETCH, 1, 0, 0, 1, 0, 0, 1'($urandom), 1, 1'($urandom));
    for (int i = 0; i < sd; i++) cyc(S_DEC, 0, 0, 0, 0, 0, 0, 1, 1'($urandom), 1'($urandom));
    cyc(S_DEC, 0, 0, 0, 0, 0, 0, 0, 1'($urandom), 1'($urandom));
    for (int i = 0; i < se; i++) cyc(S_EXE, 0, 0, 0, 0, 0, 0, 1, 1'($urandom), 1'($urandom));
    cyc(S_EXE, 0, 0, 0, 0, 1'(kind == K_BR), 0, 0, 1'($urandom), 1'($urandom));
    if (is_mem) begin
      for (int i = 0; i < md; i++) cyc(S_MEM, 0, 1, st, 0, 0, 0, 1'($urandom), 1'($urandom), 0);
      cyc(S_MEM, 0, 1, st, 0, st, 0, 1'($urandom), 1'($urandom), 1);
    end
    if (is_wb) begin
      for (int i = 0; i < sw; i++) cyc(S_WB, 0, 0, 0, 0, 0, 0, 1, 1'($urandom), 1'($urandom));
      cyc(S_WB, 0, 0, 0, 0, 1, 1, 0, 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    #12;
    check_eq("reset_outputs", obs(), 32'd0);
    check_eq("reset_cnt", 32'(instr_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(S_IDLE, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    run_instr(K_R,  0, 0, 0, 0, 0);
    run_instr(K_LD, 0, 0, 0, 2, 0);
    run_instr(K_ST, 0, 0, 0, 0, 0);
    run_instr(K_BR, 0, 0, 0, 0, 0);
    run_instr(K_BR, 0, 2, 0, 0, 0);
    run_instr(K_R,  2, 1, 1, 0, 2);

`ifdef SEQ_TIMEOUT_EN
    run_instr(K_R,  15, 0, 0, 0, 0);
    run_instr(K_LD, 0, 0, 0, 15, 0);
`else
    run_instr(K_R,  40, 0, 0, 0, 0);
    run_instr(K_ST, 0, 0, 0, 40, 0);
`endif

    for (int n = 0; n < 150; n++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
    end

    set_flags(K_LD);
    cyc(S_FETCH, 1, 0, 0, 1, 0, 0, 0, 1, 0);
    cyc(S_DEC, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(S_EXE, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stall_i  = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #2;
    check_eq("mem_req_before_reset", 32'(dmem_req), 32'd1);
    do_reset();
    run_instr(K_R, 0, 0, 0, 0, 0);

`ifdef SEQ_TIMEOUT_EN
    set_flags(K_R);
    for (int i = 0; i < 16; i++) cyc(S_FETCH, 1, 0, 0, 0, 0, 0, 1'($urandom), 0, 1'($urandom));
    for (int i = 0; i < 3; i++) cyc(S_FLT, 0, 0, 0, 0, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom));
    do_reset();
    set_flags(K_ST);
    cyc(S_FETCH, 1, 0, 0, 1, 0, 0, 0, 1, 0);
    cyc(S_DEC, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(S_EXE, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(S_MEM, 0, 1, 1, 0, 0, 0, 1'($urandom), 1'($urandom), 0);
    cyc(S_FLT, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    do_reset();
`endif

    run_instr(K_BR, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
